uart_boot_loader: RTL and testbench

//  UART programming front end that feeds the upg_* port group of the instruction ROM and data memory.
//  - Receives a framed byte stream on rx_i and assembles little-endian 32-bit words.
//  - Issues one single-cycle write per word to sequential word addresses.
//  - Holds upg_done_o low for the whole session so memories select the UART port over the CPU.
//  - upg_done_o returns high when the session completes or aborts.

---
 rtl/uart_boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART programming front end: receives a length-prefixed 8N1 byte stream and
// writes little-endian 32-bit words to sequential upg_* memory addresses.
module uart_boot_loader #(
    parameter int CLK_FREQ_HZ    = 10_000_000,
    parameter int BAUD           = 128_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upg_start_i,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_FINISH} state_t;

    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t       rx_state_reg;
    logic [CW-1:0]   clk_cnt_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      rx_byte_reg;
    logic            byte_vld_reg;
    logic            frame_err_reg;

    state_t          state_reg;
    logic            start_armed_reg;
    logic [7:0]      n_lo_reg;
    logic [14:0]     words_left_reg;
    logic [14:0]     addr_cnt_reg;
    logic [23:0]     word_reg;
    logic [1:0]      byte_idx_reg;
    logic [TW-1:0]   timer_reg;
    logic            timing;
    logic            abort;
    logic [14:0]     n_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_reg  <= RX_IDLE;
            clk_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_byte_reg   <= '0;
            byte_vld_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            byte_vld_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    clk_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) rx_state_reg <= RX_START;
                end
                RX_START: begin
                    // Mid-start re-check rejects short low glitches.
                    if (clk_cnt_reg == HALF_LAST) begin
                        clk_cnt_reg  <= '0;
                        bit_cnt_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg  <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) begin
                            rx_byte_reg  <= shift_reg;
                            byte_vld_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    assign timing = (state_reg == S_HDR0) || (state_reg == S_HDR1) || (state_reg == S_DATA);
    assign abort  = frame_err_reg || (timer_reg == TIMER_LAST);
    assign n_next = {rx_byte_reg[6:0], n_lo_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            start_armed_reg <= 1'b1;
            n_lo_reg        <= '0;
            words_left_reg  <= '0;
            addr_cnt_reg    <= '0;
            word_reg        <= '0;
            byte_idx_reg    <= '0;
            timer_reg       <= '0;
            upg_wen_o       <= 1'b0;
            upg_adr_o       <= '0;
            upg_dat_o       <= '0;
            upg_done_o      <= 1'b1;
            upg_err_o       <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;
            // A low level on upg_start_i re-arms; a held-high start cannot retrigger.
            if (!upg_start_i) start_armed_reg <= 1'b1;
            if (timing && !byte_vld_reg) timer_reg <= timer_reg + 1'b1;
            else                         timer_reg <= '0;

            case (state_reg)
                S_IDLE: begin
                    upg_done_o <= 1'b1;
                    if (upg_start_i && start_armed_reg) begin
                        state_reg       <= S_HDR0;
                        start_armed_reg <= 1'b0;
                        upg_err_o       <= 1'b0;
                        addr_cnt_reg    <= '0;
                        upg_done_o      <= 1'b0;
                    end
                end
                S_HDR0, S_HDR1, S_DATA: begin
                    if (byte_vld_reg) begin
                        if (state_reg == S_HDR0) begin
                            n_lo_reg  <= rx_byte_reg;
                            state_reg <= S_HDR1;
                        end else if (state_reg == S_HDR1) begin
                            words_left_reg <= n_next;
                            byte_idx_reg   <= '0;
                            state_reg      <= (n_next == 15'd0) ? S_FINISH : S_DATA;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            case (byte_idx_reg)
                                2'd0: word_reg[7:0]   <= rx_byte_reg;
                                2'd1: word_reg[15:8]  <= rx_byte_reg;
                                2'd2: word_reg[23:16] <= rx_byte_reg;
                                default: begin
                                    upg_dat_o <= {rx_byte_reg, word_reg};
                                    upg_adr_o <= addr_cnt_reg;
                                    upg_wen_o <= 1'b1;
                                    state_reg <= S_WRITE;
                                end
                            endcase
                        end
                    end else if (abort) begin
                        upg_err_o  <= 1'b1;
                        upg_done_o <= 1'b1;
                        state_reg  <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    addr_cnt_reg   <= addr_cnt_reg + 1'b1;
                    words_left_reg <= words_left_reg - 1'b1;
                    state_reg      <= (words_left_reg == 15'd1) ? S_FINISH : S_DATA;
                end
                S_FINISH: begin
                    upg_done_o <= 1'b1;
                    state_reg  <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed-plus-random bench for uart_boot_loader: drives 8N1 frames and
// compares captured memory writes against a word-assembly reference model.
module tb_uart_boot_loader;

    localparam int CPB     = 10_000_000 / 128_000;
    localparam int TIMEOUT = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        upg_start_i;
    logic        rx_i;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        upg_err_o;

    uart_boot_loader #(
        .CLK_FREQ_HZ(10_000_000),
        .BAUD(128_000),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .upg_start_i(upg_start_i),
        .rx_i(rx_i),
        .upg_wen_o(upg_wen_o),
        .upg_adr_o(upg_adr_o),
        .upg_dat_o(upg_dat_o),
        .upg_done_o(upg_done_o),
        .upg_err_o(upg_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] adr_q[$];
    logic [31:0] dat_q[$];
    logic [7:0]  pay_q[$];
    int          wen_run = 0;
    int          wen_max = 0;
    int          writes_at_rise = -1;
    logic        done_prev = 1'b1;

    // Write capture and strobe-width tracking, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (upg_wen_o === 1'b1) begin
                adr_q.push_back(upg_adr_o);
                dat_q.push_back(upg_dat_o);
                $display("write adr=%04h dat=%08h", upg_adr_o, upg_dat_o);
                wen_run = wen_run + 1;
                if (wen_run > wen_max) wen_max = wen_run;
            end else begin
                wen_run = 0;
            end
            if (upg_done_o === 1'b1 && done_prev !== 1'b1) writes_at_rise = adr_q.size();
            done_prev = upg_done_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_payload();
        for (int i = 0; i < pay_q.size(); i++) send_byte(pay_q[i], 1'b1);
    endtask

    task automatic fill_random(input int nbytes);
        pay_q.delete();
        for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic start_session(input string tag, input bit hold);
        adr_q.delete();
        dat_q.delete();
        writes_at_rise = -1;
        wen_max = 0;
        @(negedge clk) upg_start_i = 1'b1;
        repeat (2) @(negedge clk);
        if (!hold) upg_start_i = 1'b0;
        check({tag, "_busy"}, 64'(upg_done_o), 64'(1'b0));
        check({tag, "_err_cleared"}, 64'(upg_err_o), 64'(1'b0));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (upg_done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(upg_done_o), 64'(1'b1));
    endtask

    // Reference: word i is bytes 4i..4i+3 of the payload, little-endian, at base+i.
    task automatic check_writes(input string tag, input logic [14:0] base, input int nwords);
        logic [14:0] e_adr;
        logic [31:0] e_dat;
        check({tag, "_count"}, 64'(adr_q.size()), 64'(nwords));
        for (int i = 0; i < nwords && i < adr_q.size(); i++) begin
            e_adr = base + 15'(i);
            e_dat = {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]};
            check({tag, "_adr"}, 64'(adr_q[i]), 64'(e_adr));
            check({tag, "_dat"}, 64'(dat_q[i]), 64'(e_dat));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        upg_start_i = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wen",  64'(upg_wen_o),  64'(1'b0));
        check("rst_adr",  64'(upg_adr_o),  64'(15'h0));
        check("rst_dat",  64'(upg_dat_o),  64'(32'h0));
        check("rst_done", 64'(upg_done_o), 64'(1'b1));
        check("rst_err",  64'(upg_err_o),  64'(1'b0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Two-word directed session.
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_session("t2", 0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_payload();
        wait_done("t2", 2000);
        check_writes("t2", 15'h0000, 2);
        check("t2_dat1_const", 64'(dat_q.size() > 1 ? dat_q[1] : 32'h0), 64'(32'hDDCCBBAA));
        check("t2_wen_width", 64'(wen_max), 64'(1));
        check("t2_done_after_2nd", 64'(writes_at_rise), 64'(2));
        check("t2_err", 64'(upg_err_o), 64'(1'b0));

        // Zero-length session.
        start_session("t3", 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("t3", 2000);
        check("t3_count", 64'(adr_q.size()), 64'(0));
        check("t3_err", 64'(upg_err_o), 64'(1'b0));

        // Random-length random-data session.
        n = $urandom_range(1, 2);
        fill_random(4 * n);
        start_session("rnd", 0);
        send_byte(8'(n), 1'b1);
        send_byte(8'h00, 1'b1);
        send_payload();
        wait_done("rnd", 2000);
        check_writes("rnd", 15'h0000, n);
        check("rnd_err", 64'(upg_err_o), 64'(1'b0));

        // Timeout after 1.5 words.
        fill_random(6);
        start_session("t4", 0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_payload();
        wait_done("t4", TIMEOUT + 1000);
        check_writes("t4", 15'h0000, 1);
        check("t4_err", 64'(upg_err_o), 64'(1'b1));

        // Framing error in DATA.
        fill_random(2);
        start_session("t5a", 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_payload();
        send_byte(8'h5A, 1'b0);
        wait_done("t5a", 500);
        check("t5a_count", 64'(adr_q.size()), 64'(0));
        check("t5a_err", 64'(upg_err_o), 64'(1'b1));

        // Short low glitch mid-session must not become a byte.
        fill_random(4);
        start_session("t5b", 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk) rx_i = 1'b0;
        repeat (20) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_payload();
        wait_done("t5b", 2000);
        check_writes("t5b", 15'h0000, 1);
        check("t5b_err", 64'(upg_err_o), 64'(1'b0));

        // Asynchronous reset in the middle of a session.
        fill_random(8);
        start_session("t1", 0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(pay_q[i], 1'b1);
        check("t1_pre_count", 64'(adr_q.size()), 64'(1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_wen",  64'(upg_wen_o),  64'(1'b0));
        check("t1_adr",  64'(upg_adr_o),  64'(15'h0));
        check("t1_dat",  64'(upg_dat_o),  64'(32'h0));
        check("t1_done", 64'(upg_done_o), 64'(1'b1));
        check("t1_err",  64'(upg_err_o),  64'(1'b0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 5; i < 8; i++) send_byte(pay_q[i], 1'b1);
        repeat (10) @(negedge clk);
        check("t1_no_more_writes", 64'(adr_q.size()), 64'(1));
        check("t1_idle_done", 64'(upg_done_o), 64'(1'b1));

        // ROM-to-data-memory crossing; start held high afterwards.
        fill_random(8);
        start_session("t6", 1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hC0, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_n_latched", 64'(dut.words_left_reg), 64'(15'h4001));
        force dut.addr_cnt_reg = 15'h3FFF;
        force dut.words_left_reg = 15'd2;
        @(negedge clk);
        release dut.addr_cnt_reg;
        release dut.words_left_reg;
        send_payload();
        wait_done("t6", 2000);
        check_writes("t6", 15'h3FFF, 2);
        check("t6_last_adr", 64'(adr_q.size() > 1 ? adr_q[1] : 15'h0), 64'(15'h4000));
        check("t6_wen_width", 64'(wen_max), 64'(1));
        send_byte(8'h01, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check("t6_no_restart", 64'(upg_done_o), 64'(1'b1));
        check("t6_no_new_writes", 64'(adr_q.size()), 64'(2));
        upg_start_i = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
